// File: rtl/ub_act_feeder.sv
// Unified-buffer activation feeder: streams a run of UB rows and diagonally skews them into the systolic array.
// Optional UB_FEEDER_STRIDE_EN adds a stride_i port; otherwise rows are read at consecutive addresses.
module ub_feeder_lane #(
  parameter int DW    = 9,
  parameter int DEPTH = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [DW-1:0] dat_i,
  input  logic          vld_i,
  output logic [DW-1:0] dat_o,
  output logic          vld_o
);
  generate
    if (DEPTH == 0) begin : g_pass
      assign dat_o = dat_i;
      assign vld_o = vld_i;
    end else begin : g_dly
      logic [DEPTH-1:0]         vld_pipe;
      logic [DEPTH-1:0][DW-1:0] dat_pipe;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_pipe <= '0;
          dat_pipe <= '0;
        end else if (en_i) begin
          vld_pipe[0] <= vld_i;
          dat_pipe[0] <= dat_i;
          for (int i = 1; i < DEPTH; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
          end
        end
      end
      assign dat_o = dat_pipe[DEPTH-1];
      assign vld_o = vld_pipe[DEPTH-1];
    end
  endgenerate
endmodule

module ub_act_feeder #(
  parameter int ACT_WIDTH = 8,
  parameter int MUL_SIZE  = 4,
  parameter int DW        = ACT_WIDTH + 1,
  parameter int LANES     = MUL_SIZE,
  parameter int AW        = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [AW-1:0]              base_addr_i,
  input  logic [AW-1:0]              num_rows_i,
`ifdef UB_FEEDER_STRIDE_EN
  input  logic [AW-1:0]              stride_i,
`endif
  input  logic                       stall_i,
  output logic                       ub_read_o,
  output logic [AW-1:0]              ub_addr_rd_o,
  input  logic [LANES-1:0][DW-1:0]   ub_data_i,
  output logic [LANES-1:0][DW-1:0]   act_o,
  output logic [LANES-1:0]           act_valid_o,
  output logic                       busy_o,
  output logic                       done_o
);
  localparam int DCW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                   state;
  logic [AW-1:0]            cur_addr, rows_left, stride;
  logic [DCW-1:0]           drain_cnt;
  logic                     rd_pend, adv;
  logic [LANES-1:0][DW-1:0] s0_dat;
  logic [LANES-1:0]         s0_vld;

  assign adv          = !stall_i;
  // Gated by reset so an aborted run cannot slip one last read out.
  assign ub_read_o    = (state == READ) && adv && !rst_i;
  assign ub_addr_rd_o = cur_addr;
  assign busy_o       = (state == READ) || (state == DRAIN);
  assign done_o       = (state == DONE);

`ifdef UB_FEEDER_STRIDE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                stride <= '0;
    else if (state == IDLE && start_i)        stride <= stride_i;
  end
`else
  assign stride = AW'(1);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rows_left <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          cur_addr  <= base_addr_i;
          rows_left <= num_rows_i;
          state     <= (num_rows_i != '0) ? READ : DONE;
        end
        READ: if (adv) begin
          cur_addr  <= cur_addr + stride;
          rows_left <= rows_left - AW'(1);
          if (rows_left == AW'(1)) begin
            state     <= DRAIN;
            drain_cnt <= DCW'(LANES - 1);
          end
        end
        // LANES cycles in DRAIN lets the last row clear the deepest lane.
        DRAIN: if (adv) begin
          if (drain_cnt == '0) state <= DONE;
          else                 drain_cnt <= drain_cnt - DCW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0: zero the data of invalid rows so padding lanes read as 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend <= 1'b0;
      s0_vld  <= '0;
      s0_dat  <= '0;
    end else if (adv) begin
      rd_pend <= ub_read_o;
      s0_vld  <= {LANES{rd_pend}};
      for (int k = 0; k < LANES; k++)
        s0_dat[k] <= rd_pend ? ub_data_i[k] : '0;
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      ub_feeder_lane #(.DW(DW), .DEPTH(k)) u_lane (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (adv),
        .dat_i (s0_dat[k]),
        .vld_i (s0_vld[k]),
        .dat_o (act_o[k]),
        .vld_o (act_valid_o[k])
      );
    end
  endgenerate
endmodule
